// File: rtl/bcd_pkg.sv
// Shared BCD helpers for the wall-clock counters: digit width, digit check and
// binary<->packed-BCD conversions (up to four digits, digit 0 in bits [3:0]).
package bcd_pkg;

    localparam int BCD_W = 4;

    function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

    function automatic logic [15:0] bin_to_bcd(input int v);
        logic [15:0] r;
        int          n;
        r = '0;
        n = v;
        for (int i = 0; i < 4; i++) begin
            r[BCD_W*i +: BCD_W] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic int bcd_to_bin(input logic [15:0] b);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            r = r * 10 + int'(b[BCD_W*i +: BCD_W]);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the modulo counter; steps up/down when en and cin are high.
// Latency: digit registered, cout combinational. No backpressure: clear > load > step.
// cout asserts when this digit rolls over (9 going up, 0 going down) with cin set.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             cin,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_dig,
    output logic [BCD_W-1:0] dig,
    output logic             cout
);

    assign cout = cin & (up_dn ? (dig == 4'd9) : (dig == 4'd0));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dig <= '0;
        end else if (load) begin
            dig <= load_dig;
        end else if (en && cin) begin
            if (up_dn) begin
                dig <= (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
                dig <= (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD modulo-N counter with load check and carry/borrow pulses.
// Latency: one cycle from en/load to value; pulses aligned with the new value.
// No backpressure; define BCD_CNT_SAT_EN to saturate instead of wrapping.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MODULO = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] value,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err,
    output logic                  at_max
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [15:0]  MAX_BCD16 = bin_to_bcd(MODULO - 1);
    localparam logic [W-1:0] MAX_BCD   = MAX_BCD16[W-1:0];

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be 1..4");
    end
    if (MODULO < 2 || MODULO > 10**DIGITS) begin : g_bad_modulo
        $error("bcd_mod_counter: MODULO must be 2..10**DIGITS");
    end

    logic          load_ok;
    logic          tick;
    logic          at_zero;
    logic          wrap_up;
    logic          wrap_dn;
    logic          step;
    logic          dig_clear;
    logic          dig_load;
    logic [W-1:0]  dig_ld_val;
    logic [DIGITS:0] ripple;
    logic          ripple_unused;

    always_comb begin
        load_ok = (bcd_to_bin(16'(load_val)) < MODULO);
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(load_val[BCD_W*i +: BCD_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    assign at_max  = (value == MAX_BCD);
    assign at_zero = (value == '0);
    assign tick    = en & ~load;
    assign wrap_up = tick & up_dn & at_max;
    assign wrap_dn = tick & ~up_dn & at_zero;

`ifdef BCD_CNT_SAT_EN
    // At a boundary the digits simply hold; only the pulse records the attempt.
    assign step       = tick & ~wrap_up & ~wrap_dn;
    assign dig_clear  = load & ~load_ok;
    assign dig_load   = load & load_ok;
    assign dig_ld_val = load_val;
`else
    // Modulus wrap reuses the digit clear/load paths rather than the ripple.
    assign step       = tick;
    assign dig_clear  = (load & ~load_ok) | wrap_up;
    assign dig_load   = (load & load_ok) | wrap_dn;
    assign dig_ld_val = load ? load_val : MAX_BCD;
`endif

    assign ripple[0]     = 1'b1;
    assign ripple_unused = ripple[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .en       (step),
            .up_dn    (up_dn),
            .cin      (ripple[g]),
            .clear    (dig_clear),
            .load     (dig_load),
            .load_dig (dig_ld_val[BCD_W*g +: BCD_W]),
            .dig      (value[BCD_W*g +: BCD_W]),
            .cout     (ripple[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= wrap_up;
            borrow   <= wrap_dn;
            load_err <= load & ~load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a MODULO=60 and a MODULO=24 instance,
// expectations follow BCD_CNT_SAT_EN when the bench is built with it.
module tb_bcd_mod_counter;

`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0;
    logic [7:0] a_lv = '0, a_value;
    logic       a_carry, a_borrow, a_err, a_max;

    logic       b_reset = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0;
    logic [7:0] b_lv = '0, b_value;
    logic       b_carry, b_borrow, b_err, b_max;

    int tests_run = 0;
    int tests_failed = 0;

    bcd_mod_counter #(.DIGITS(2), .MODULO(60)) dut60 (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .value(a_value), .carry(a_carry), .borrow(a_borrow),
        .load_err(a_err), .at_max(a_max)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULO(24)) dut24 (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .value(b_value), .carry(b_carry), .borrow(b_borrow),
        .load_err(b_err), .at_max(b_max)
    );

    function automatic logic [7:0] tb_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // One clock on the mod-60 instance; outputs are sampled 1 ns after the edge.
    task automatic step_a(input logic rst, input logic e, input logic ud,
                          input logic ld, input logic [7:0] lv);
        a_reset = rst; a_en = e; a_up = ud; a_load = ld; a_lv = lv;
        @(posedge clk); #1;
        a_reset = 1'b0; a_en = 1'b0; a_load = 1'b0;
    endtask

    task automatic step_b(input logic rst, input logic e, input logic ud,
                          input logic ld, input logic [7:0] lv);
        b_reset = rst; b_en = e; b_up = ud; b_load = ld; b_lv = lv;
        @(posedge clk); #1;
        b_reset = 1'b0; b_en = 1'b0; b_load = 1'b0;
    endtask

    task automatic test_reset;
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_carry, a_borrow, a_err, a_max} !== {8'h00, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset: got val=%h c=%b b=%b e=%b max=%b, want 00/0/0/0/0",
                     a_value, a_carry, a_borrow, a_err, a_max);
        end
    endtask

    task automatic test_count_up;
        logic [7:0] exp_v;
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 60; i++) begin
            step_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            exp_v = (i == 60) ? (SAT ? 8'h59 : 8'h00) : tb_bcd(i);
            tests_run++;
            if ({a_value, a_carry, a_borrow, a_max} !==
                {exp_v, (i == 60), 1'b0, (exp_v == 8'h59)}) begin
                tests_failed++;
                $display("FAIL count_up[%0d]: got val=%h c=%b b=%b max=%b, want val=%h c=%b max=%b",
                         i, a_value, a_carry, a_borrow, a_max, exp_v, (i == 60), (exp_v == 8'h59));
            end
        end
        // second consecutive up-tick past the top
        step_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_carry} !== (SAT ? {8'h59, 1'b1} : {8'h01, 1'b0})) begin
            tests_failed++;
            $display("FAIL up_after_top: got val=%h c=%b, want %h/%b",
                     a_value, a_carry, SAT ? 8'h59 : 8'h01, SAT);
        end
    endtask

    task automatic test_count_down;
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_carry, a_borrow} !== {(SAT ? 8'h00 : 8'h59), 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL down_wrap: got val=%h c=%b b=%b, want %h/0/1",
                     a_value, a_carry, a_borrow, SAT ? 8'h00 : 8'h59);
        end
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_borrow} !== (SAT ? {8'h00, 1'b1} : {8'h58, 1'b0})) begin
            tests_failed++;
            $display("FAIL down_next: got val=%h b=%b, want %h/%b",
                     a_value, a_borrow, SAT ? 8'h00 : 8'h58, SAT);
        end
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_carry, a_borrow, a_err} !== {(SAT ? 8'h00 : 8'h58), 3'b000}) begin
            tests_failed++;
            $display("FAIL hold: got val=%h c=%b b=%b e=%b, want %h/0/0/0",
                     a_value, a_carry, a_borrow, a_err, SAT ? 8'h00 : 8'h58);
        end
    endtask

    task automatic test_load;
        logic [7:0] lv_tab  [4] = '{8'h45, 8'h5A, 8'h37, 8'h60};
        logic [7:0] val_tab [4] = '{8'h45, 8'h00, 8'h37, 8'h00};
        logic       err_tab [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1, lv_tab[i]);
            tests_run++;
            if ({a_value, a_err, a_carry, a_borrow} !== {val_tab[i], err_tab[i], 2'b00}) begin
                tests_failed++;
                $display("FAIL load[%h]: got val=%h err=%b c=%b b=%b, want %h/%b/0/0",
                         lv_tab[i], a_value, a_err, a_carry, a_borrow, val_tab[i], err_tab[i]);
            end
        end
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (a_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_err_pulse: got err=%b, want 0", a_err);
        end
    endtask

    task automatic test_load_priority;
        step_a(1'b0, 1'b1, 1'b1, 1'b1, 8'h59);
        tests_run++;
        if ({a_value, a_carry, a_max} !== {8'h59, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL load_over_en: got val=%h c=%b max=%b, want 59/0/1",
                     a_value, a_carry, a_max);
        end
        step_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({a_value, a_carry} !== {(SAT ? 8'h59 : 8'h00), 1'b1}) begin
            tests_failed++;
            $display("FAIL en_after_load: got val=%h c=%b, want %h/1",
                     a_value, a_carry, SAT ? 8'h59 : 8'h00);
        end
        // invalid load with en=1 down at zero: load wins, no borrow
        step_a(1'b0, 1'b1, 1'b0, 1'b1, 8'h9F);
        tests_run++;
        if ({a_value, a_err, a_borrow} !== {8'h00, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL bad_load_over_en: got val=%h err=%b b=%b, want 00/1/0",
                     a_value, a_err, a_borrow);
        end
    endtask

    task automatic test_mod24;
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
        step_b(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({b_value, b_carry, b_max} !== {8'h23, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL m24_23: got val=%h c=%b max=%b, want 23/0/1", b_value, b_carry, b_max);
        end
        step_b(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({b_value, b_carry} !== {(SAT ? 8'h23 : 8'h00), 1'b1}) begin
            tests_failed++;
            $display("FAIL m24_wrap: got val=%h c=%b, want %h/1",
                     b_value, b_carry, SAT ? 8'h23 : 8'h00);
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h24);
        tests_run++;
        if ({b_value, b_err} !== {8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL m24_load24: got val=%h err=%b, want 00/1", b_value, b_err);
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if ({b_value, b_borrow} !== {8'h09, 1'b0}) begin
            tests_failed++;
            $display("FAIL m24_ripple_down: got val=%h b=%b, want 09/0", b_value, b_borrow);
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h13);
        step_b(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if ({b_value, b_carry, b_err} !== {8'h00, 2'b00}) begin
            tests_failed++;
            $display("FAIL m24_reset_mid: got val=%h c=%b e=%b, want 00/0/0",
                     b_value, b_carry, b_err);
        end
        step_b(1'b1, 1'b0, 1'b0, 1'b1, 8'h15);
        tests_run++;
        if (b_value !== 8'h00) begin
            tests_failed++;
            $display("FAIL m24_reset_over_load: got val=%h, want 00", b_value);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_load_priority();
        test_mod24();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
